// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready load/store with wait states and byte/half lanes.
// Optional macro DMEM_ERR_EN: flag misaligned accesses with rsp_err instead of force-aligning them.
module dmem_responder #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = ADDR_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              accept, access;

  logic              h_we;
  logic [1:0]        h_size;
  logic              h_signed;
  logic [ADDR_W-1:0] h_addr;
  logic [31:0]       h_wdata;

  logic [31:0]       mem [DEPTH];
  logic [IDX_W-1:0]  widx;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [31:0]       wword, rword, shifted, ld_data;
  logic              err_hit;

  // Next-state: WAIT with a zero count is the single access cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    access  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_n   = CNT_W'(WAIT);
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          access  = 1'b1;
          state_n = S_RESP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef DMEM_ERR_EN
  assign err_hit = ((h_size == 2'b01) && h_addr[0]) ||
                   (h_size[1] && (h_addr[1:0] != 2'b00));
`else
  assign err_hit = 1'b0;
`endif

  // Lane steering for stores and extraction/extension for loads
  always_comb begin
    widx    = h_addr[ADDR_W-1:2];
    lane    = h_addr[1:0];
    rword   = mem[widx];
    be      = '0;
    wword   = '0;
    shifted = '0;
    ld_data = '0;
    case (h_size)
      2'b00: begin
        be      = 4'b0001 << lane;
        wword   = {4{h_wdata[7:0]}};
        shifted = rword >> {lane, 3'b000};
        ld_data = h_signed ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      end
      2'b01: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        wword   = {2{h_wdata[15:0]}};
        shifted = rword >> {lane[1], 4'b0000};
        ld_data = h_signed ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
      end
      default: begin
        be      = 4'b1111;
        wword   = h_wdata;
        ld_data = rword;
      end
    endcase
  end

  // Array write; not reset, commits on the edge that enters RESP
  always_ff @(posedge clk) begin
    if (access && h_we && !err_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  // State register and handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      req_ready <= (state_n == S_IDLE);
      rsp_valid <= (state_n == S_RESP);
    end
  end

  // Request holding and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_we      <= 1'b0;
      h_size    <= '0;
      h_signed  <= 1'b0;
      h_addr    <= '0;
      h_wdata   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        h_we     <= req_we;
        h_size   <= req_size;
        h_signed <= req_signed;
        h_addr   <= req_addr;
        h_wdata  <= req_wdata;
      end
      if (access) begin
        rsp_err   <= err_hit;
        rsp_rdata <= (h_we || err_hit) ? '0 : ld_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array transaction model.
module tb_dmem_responder;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned WAIT_C = 2;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT(WAIT_C)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference memory and transaction model
  logic [7:0] mem_m [0:(1<<ADDR_W)-1];

  function automatic void model_access(input logic we, input logic [1:0] sz, input logic sg,
                                       input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic er);
    int nb, base;
    longint unsigned v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    rd = '0;
    er = 1'b0;
`ifdef DMEM_ERR_EN
    if ((int'(a) % nb) != 0) begin
      er = 1'b1;
      return;
    end
`endif
    base = int'(a) - (int'(a) % nb);
    if (we) begin
      for (int i = 0; i < nb; i++) mem_m[base+i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v + (64'(mem_m[base+i]) << (8*i));
      if (sg && v[8*nb-1]) v = v - (64'd1 << (8*nb));
      rd = v[31:0];
    end
  endfunction

  logic              m_busy = 1'b0, m_resp = 1'b0;
  int                m_cnt = 0;
  logic              m_we, m_sg;
  logic [1:0]        m_sz;
  logic [ADDR_W-1:0] m_a;
  logic [31:0]       m_wd, m_rdata;
  logic              m_err;

  // Model advances on each edge from sampled inputs; outputs compared just after
  always begin
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0;
      m_resp = 1'b0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1'b1;
        m_cnt  = WAIT_C + 1;
        m_we = req_we; m_sz = req_size; m_sg = req_signed; m_a = req_addr; m_wd = req_wdata;
      end
    end else if (!m_resp) begin
      m_cnt--;
      if (m_cnt == 0) begin
        model_access(m_we, m_sz, m_sg, m_a, m_wd, m_rdata, m_err);
        m_resp = 1'b1;
      end
    end else if (rsp_ready) begin
      m_busy = 1'b0;
      m_resp = 1'b0;
    end
    #1;
    chk("mon_req_ready", 32'(req_ready), 32'(!m_busy));
    chk("mon_rsp_valid", 32'(rsp_valid), 32'(m_resp));
    if (m_resp) begin
      chk("mon_rsp_rdata", rsp_rdata, m_rdata);
      chk("mon_rsp_err", 32'(rsp_err), 32'(m_err));
    end
  end

  task automatic scramble();
    req_valid  = 1'($urandom_range(0, 1));
    req_we     = 1'($urandom_range(0, 1));
    req_size   = 2'($urandom);
    req_signed = 1'($urandom_range(0, 1));
    req_addr   = ADDR_W'($urandom);
    req_wdata  = $urandom;
  endtask

  // One full transaction; starts and ends at a falling edge
  task automatic txn(input logic we, input logic [1:0] sz, input logic sg,
                     input logic [ADDR_W-1:0] a, input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er);
    int n, lat;
    rd = '0;
    er = 1'b0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      scramble();
      @(posedge clk);
      #1;
      lat++;
    end while (!rsp_valid && lat < 40);
    chk("latency", 32'(lat), 32'(WAIT_C + 1));
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      scramble();
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    scramble();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    if (hold > 0) chk("ready_after_hs", 32'(req_ready), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          n;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Give the low 128 bytes known contents
    for (int i = 0; i < 32; i++) txn(1'b1, 2'b10, 1'b0, ADDR_W'(4*i), $urandom, 0, rd, er);

    // Word round-trip
    txn(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 0, rd, er);
    chk("store_rdata_zero", rd, 32'd0);
    txn(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 0, rd, er);
    chk("word_rt", rd, 32'hDEADBEEF);

    // Byte store and extension
    txn(1'b1, 2'b00, 1'b0, 12'h013, 32'h00000080, 0, rd, er);
    txn(1'b0, 2'b00, 1'b1, 12'h013, 32'h0, 0, rd, er);
    chk("byte_signed", rd, 32'hFFFFFF80);
    txn(1'b0, 2'b00, 1'b0, 12'h013, 32'h0, 0, rd, er);
    chk("byte_unsigned", rd, 32'h00000080);
    txn(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 0, rd, er);
    chk("byte_word", rd, 32'h80ADBEEF);

    // Halfword lanes
    txn(1'b1, 2'b10, 1'b0, 12'h020, 32'h55667788, 0, rd, er);
    txn(1'b1, 2'b01, 1'b0, 12'h022, 32'hFFFF1234, 0, rd, er);
    txn(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 0, rd, er);
    chk("half_lanes", rd, 32'h12347788);
    txn(1'b0, 2'b01, 1'b1, 12'h020, 32'h0, 0, rd, er);
    chk("half_signed", rd, 32'h00007788);

    // Backpressure
    txn(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 5, rd, er);
    chk("bp_rdata", rd, 32'h80ADBEEF);

    // Reset during WAIT drops the store
    txn(1'b1, 2'b10, 1'b0, 12'h040, 32'h11223344, 0, rd, er);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 12'h040; req_wdata = 32'hAAAAAAAA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstwait_req_ready", 32'(req_ready), 32'd1);
    chk("rstwait_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 2'b10, 1'b0, 12'h040, 32'h0, 0, rd, er);
    chk("rstwait_keep", rd, 32'h11223344);

    // Reset during RESP keeps the committed store
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 12'h044; req_wdata = 32'h0BADF00D;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rstresp_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstresp_drop", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 2'b10, 1'b0, 12'h044, 32'h0, 0, rd, er);
    chk("rstresp_keep", rd, 32'h0BADF00D);

    // Misaligned word
    txn(1'b0, 2'b10, 1'b0, 12'h041, 32'h0, 0, rd, er);
`ifdef DMEM_ERR_EN
    chk("misaligned_rdata", rd, 32'd0);
    chk("misaligned_err", 32'(er), 32'd1);
`else
    chk("misaligned_rdata", rd, 32'h11223344);
    chk("misaligned_err", 32'(er), 32'd0);
`endif

    // Random traffic within the initialised region
    for (int i = 0; i < 300; i++) begin
      txn(1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom_range(0, 1)),
          ADDR_W'($urandom_range(0, 127)), $urandom, $urandom_range(0, 3), rd, er);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
